// File: rtl/spi_slave_if.sv
// SPI slave front end: MOSI frames -> 10-bit RAM command words, RAM read data -> MISO.
// Latency: rx_valid one cycle after bit 0 is sampled; MISO bit 7 one cycle after tx_valid.
// Backpressure: none; SS_n high aborts any frame. Optional frame_err output under SPI_FRAME_ERR_EN.
module spi_slave_if #(
   parameter int RX_WIDTH = 10,   // 2 command bits + TX_WIDTH address/data bits
   parameter int TX_WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                SS_n,
   input  logic                MOSI,
   output logic                MISO,
   output logic [RX_WIDTH-1:0] rx_data,
   output logic                rx_valid,
   input  logic [TX_WIDTH-1:0] tx_data,
   input  logic                tx_valid
`ifdef SPI_FRAME_ERR_EN
   ,
   output logic                frame_err
`endif
);

   localparam int RCW = $clog2(RX_WIDTH);
   localparam int TCW = $clog2(TX_WIDTH + 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_CHK_CMD   = 3'd1,
      S_WRITE     = 3'd2,
      S_READ_ADD  = 3'd3,
      S_READ_DATA = 3'd4
   } state_t;

   state_t                r_state;
   logic [RX_WIDTH-2:0]   r_rx_shift;     // bits received so far, newest in LSB
   logic [RCW-1:0]        r_rx_cnt;       // number of frame bits already captured
   logic                  r_rx_done;      // full word received in this frame
   logic                  r_rd_addr_seen; // a read address is pending its read-data frame
   logic [RX_WIDTH-1:0]   r_rx_data;
   logic                  r_rx_valid;
   logic                  r_miso;
   logic [TX_WIDTH-2:0]   r_tx_shift;     // remaining read-data bits after the one on MISO
   logic [TCW-1:0]        r_tx_cnt;       // read-data bits driven so far
   logic                  r_tx_busy;
   logic                  r_tx_all;       // last read-data bit has been driven; blocks reloads

`ifdef SPI_FRAME_ERR_EN
   logic                  r_frame_err;
   logic                  w_rx_phase;
   logic                  w_tx_pending;

   // An abort counts as an error when a word or the read-data burst is still incomplete.
   assign w_rx_phase   = (r_state == S_CHK_CMD) ||
                         (((r_state == S_WRITE) || (r_state == S_READ_ADD) ||
                           (r_state == S_READ_DATA)) && !r_rx_done);
   assign w_tx_pending = (r_state == S_READ_DATA) && r_rx_done && !r_tx_all;
   assign frame_err    = r_frame_err;
`endif

   assign MISO     = r_miso;
   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;

   // Frame FSM: receive, command decode, read-data serialisation and abort handling.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_rx_shift     <= '0;
         r_rx_cnt       <= '0;
         r_rx_done      <= 1'b0;
         r_rd_addr_seen <= 1'b0;
         r_rx_data      <= '0;
         r_rx_valid     <= 1'b0;
         r_miso         <= 1'b0;
         r_tx_shift     <= '0;
         r_tx_cnt       <= '0;
         r_tx_busy      <= 1'b0;
         r_tx_all       <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
         r_frame_err    <= 1'b0;
`endif
      end else begin
         r_rx_valid <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
         r_frame_err <= 1'b0;
`endif
         if ((r_state != S_IDLE) && SS_n) begin
            // Abort wins over everything, including a bit-0 capture on this edge.
            r_state   <= S_IDLE;
            r_rx_cnt  <= '0;
            r_rx_done <= 1'b0;
            r_miso    <= 1'b0;
            r_tx_cnt  <= '0;
            r_tx_busy <= 1'b0;
            r_tx_all  <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            r_frame_err <= w_rx_phase || w_tx_pending;
`endif
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (!SS_n) begin
                     r_state   <= S_CHK_CMD;
                     r_rx_cnt  <= '0;
                     r_rx_done <= 1'b0;
                     r_tx_cnt  <= '0;
                     r_tx_busy <= 1'b0;
                     r_tx_all  <= 1'b0;
                  end
               end
               S_CHK_CMD: begin
                  // This bit is rx bit 9; with a pending read address a read frame is read-data.
                  r_rx_shift <= {r_rx_shift[RX_WIDTH-3:0], MOSI};
                  r_rx_cnt   <= RCW'(1);
                  if (!MOSI)
                     r_state <= S_WRITE;
                  else if (!r_rd_addr_seen)
                     r_state <= S_READ_ADD;
                  else
                     r_state <= S_READ_DATA;
               end
               S_WRITE, S_READ_ADD, S_READ_DATA: begin
                  if (!r_rx_done) begin
                     r_rx_shift <= {r_rx_shift[RX_WIDTH-3:0], MOSI};
                     if (r_rx_cnt == RCW'(RX_WIDTH - 1)) begin
                        r_rx_data  <= {r_rx_shift, MOSI};
                        r_rx_valid <= 1'b1;
                        r_rx_done  <= 1'b1;
                        if (r_state == S_READ_ADD)
                           r_rd_addr_seen <= 1'b1;
                        else if (r_state == S_READ_DATA)
                           r_rd_addr_seen <= 1'b0;
                     end else begin
                        r_rx_cnt <= r_rx_cnt + RCW'(1);
                     end
                  end else if (r_state == S_READ_DATA) begin
                     if (!r_tx_busy && !r_tx_all) begin
                        // Only the first tx_valid of the frame is taken.
                        if (tx_valid) begin
                           r_miso     <= tx_data[TX_WIDTH-1];
                           r_tx_shift <= tx_data[TX_WIDTH-2:0];
                           r_tx_cnt   <= TCW'(1);
                           r_tx_busy  <= 1'b1;
                        end
                     end else if (r_tx_busy) begin
                        if (r_tx_cnt == TCW'(TX_WIDTH)) begin
                           r_miso    <= 1'b0;
                           r_tx_busy <= 1'b0;
                        end else begin
                           r_miso     <= r_tx_shift[TX_WIDTH-2];
                           r_tx_shift <= {r_tx_shift[TX_WIDTH-3:0], 1'b0};
                           r_tx_cnt   <= r_tx_cnt + TCW'(1);
                           if (r_tx_cnt == TCW'(TX_WIDTH - 1))
                              r_tx_all <= 1'b1;
                        end
                     end
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_if.sv
// Self-checking bench for spi_slave_if: directed frames from the test plan plus random frames.
// Reference model tracks only whether a read address is pending and the expected MISO bit stream.
module tb_spi_slave_if;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
`ifdef SPI_FRAME_ERR_EN
   logic       frame_err;
`endif

   int total = 0;
   int bad   = 0;
   bit m_seen;   // model: a read address frame has completed and awaits its read-data frame

   always #5 clk = ~clk;

   spi_slave_if #(.RX_WIDTH(10), .TX_WIDTH(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .SS_n     (SS_n),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid)
`ifdef SPI_FRAME_ERR_EN
      ,
      .frame_err(frame_err)
`endif
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One clock: inputs were set before, outputs are sampled on the falling edge.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_err(input string tag, input bit exp);
`ifdef SPI_FRAME_ERR_EN
      chk(tag, {9'd0, frame_err}, {9'd0, exp});
`endif
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      SS_n     = 1'b1;
      MOSI     = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      cyc();
      cyc();
      chk("rst_miso", {9'd0, MISO}, 10'd0);
      chk("rst_rx_valid", {9'd0, rx_valid}, 10'd0);
      chk("rst_rx_data", rx_data, 10'd0);
      chk_err("rst_frame_err", 1'b0);
      rst_n  = 1'b1;
      m_seen = 1'b0;
   endtask

   // One SS_n-framed transaction.
   //   nbits  : frame bits sent before SS_n rises (10 = complete word)
   //   give_tx: return tx_valid one cycle after rx_valid (plus an ignored second pulse)
   //   tail   : cycles SS_n stays low after rx_valid
   //   rst_mid: pulse rst_n low in the tail, during read-data transmission
   task automatic frame(input logic [9:0] w, input int nbits, input bit give_tx,
                        input logic [7:0] txd, input int tail, input bit rst_mid);
      bit   rd_data;
      logic exp_miso;
      rd_data  = w[9] && m_seen;
      SS_n     = 1'b0;
      MOSI     = 1'($urandom);
      tx_valid = 1'b0;
      cyc();
      chk("idle_exit_rx_valid", {9'd0, rx_valid}, 10'd0);
      chk("idle_exit_miso", {9'd0, MISO}, 10'd0);
      for (int i = 0; i < nbits && i < 10; i++) begin
         MOSI     = w[9-i];
         tx_valid = 1'($urandom);
         tx_data  = 8'($urandom);
         cyc();
         chk("rx_valid_bit", {9'd0, rx_valid}, (i == 9) ? 10'd1 : 10'd0);
         if (i == 9) chk("rx_data", rx_data, w);
         chk("rx_miso", {9'd0, MISO}, 10'd0);
         chk_err("rx_frame_err", 1'b0);
      end
      tx_valid = 1'b0;
      if (nbits < 10) begin
         SS_n = 1'b1;
         cyc();
         chk("abort_rx_valid", {9'd0, rx_valid}, 10'd0);
         chk("abort_miso", {9'd0, MISO}, 10'd0);
         chk_err("abort_frame_err", 1'b1);
         return;
      end
      // Completed receive: a read address becomes pending, a read data consumes it.
      if (w[9] && !m_seen)     m_seen = 1'b1;
      else if (w[9] && m_seen) m_seen = 1'b0;
      for (int p = 0; p < tail; p++) begin
         MOSI     = 1'($urandom);
         tx_valid = give_tx && (p == 1 || p == 5);
         tx_data  = (p == 1) ? txd : 8'($urandom);
         if (rst_mid && p == 4) begin
            rst_n    = 1'b0;
            SS_n     = 1'b1;
            tx_valid = 1'b0;
            cyc();
            rst_n  = 1'b1;
            m_seen = 1'b0;
            chk("midrst_miso", {9'd0, MISO}, 10'd0);
            chk("midrst_rx_valid", {9'd0, rx_valid}, 10'd0);
            chk_err("midrst_frame_err", 1'b0);
            return;
         end
         cyc();
         exp_miso = (rd_data && give_tx && p >= 1 && p <= 8) ? txd[8-p] : 1'b0;
         chk("tx_miso", {9'd0, MISO}, {9'd0, exp_miso});
         chk("tail_rx_valid", {9'd0, rx_valid}, 10'd0);
         chk_err("tail_frame_err", 1'b0);
      end
      SS_n     = 1'b1;
      tx_valid = 1'b0;
      cyc();
      chk("end_miso", {9'd0, MISO}, 10'd0);
      chk("end_rx_valid", {9'd0, rx_valid}, 10'd0);
      chk_err("end_frame_err", rd_data && !(give_tx && tail >= 9));
   endtask

   initial begin
      do_reset();
      // write address, write data
      frame(10'h00A, 10, 1'b0, 8'h00, 3, 1'b0);
      frame(10'h155, 10, 1'b0, 8'h00, 4, 1'b0);
      // read address: tx_valid offered but MISO must stay low
      frame(10'h20A, 10, 1'b1, 8'hA5, 12, 1'b0);
      // read data: 8'h55 on MISO
      frame(10'h300, 10, 1'b1, 8'h55, 12, 1'b0);
      // address pending flag was cleared: this is a read address again
      frame(10'h300, 10, 1'b1, 8'hC3, 12, 1'b0);
      // read data interrupted by reset mid transmit
      frame(10'h3C5, 10, 1'b1, 8'h96, 12, 1'b1);
      // fresh reset then 3FF: read address, no MISO activity
      do_reset();
      frame(10'h3FF, 10, 1'b1, 8'hFF, 12, 1'b0);
      // write aborted after 5 bits
      frame(10'h0AB, 5, 1'b0, 8'h00, 0, 1'b0);
      // read data aborted on the bit-0 edge: no rx_valid, flag untouched
      frame(10'h3AB, 9, 1'b1, 8'h00, 0, 1'b0);
      frame(10'h311, 10, 1'b1, 8'h3C, 10, 1'b0);
      // read address then read data aborted mid transmit
      frame(10'h201, 10, 1'b0, 8'h00, 2, 1'b0);
      frame(10'h300, 10, 1'b1, 8'hE7, 5, 1'b0);
      // random frames
      for (int k = 0; k < 60; k++) begin
         frame(10'($urandom),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : 10,
               1'($urandom), 8'($urandom), int'($urandom_range(2, 13)), 1'b0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
